// File: rtl/est_pkg.sv
// Shared constants, FSM encoding and round/saturate helper for the PBCH
// channel-estimate consumers.
package est_pkg;

  localparam int IQ_W      = 16;
  localparam int FRAC      = 14;
  localparam int BASE_ADDR = 576;
  localparam int NUM_RE    = 240;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } eq_state_t;

  // Round-half-up by 2^(frac-1), arithmetic shift, clip to int16.
  // Bit IQ_W of the result is the clip indicator.
  function automatic logic [IQ_W:0] round_sat(input logic signed [32:0] s,
                                               input int frac);
    logic signed [32:0] r;
    r = (s + (33'sd1 <<< (frac - 1))) >>> frac;
    if (r > 33'sd32767)
      return {1'b1, 16'h7fff};
    else if (r < -33'sd32768)
      return {1'b1, 16'h8000};
    else
      return {1'b0, r[15:0]};
  endfunction

endpackage

// File: rtl/pbch_equalizer_cmplx_conj_mult.sv
// Two-stage rx * conj(h): products registered in stage 1, sums with
// round/saturate registered in stage 2. Valid travels alongside the data.
module cmplx_conj_mult
  import est_pkg::*;
#(
  parameter int FRAC_BITS = FRAC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  input  logic [2*IQ_W-1:0]   rx_word,
  input  logic [2*IQ_W-1:0]   h_word,
  output logic                out_vld,
  output logic [2*IQ_W-1:0]   out_word,
  output logic                out_sat
);

  logic signed [IQ_W-1:0]   a, b, c, d;
  logic signed [2*IQ_W-1:0] p_ac, p_bd, p_bc, p_ad;
  logic                     vld1_q;
  logic signed [32:0]       sum_re, sum_im;
  logic [IQ_W:0]            res_re, res_im;

  assign a = rx_word[2*IQ_W-1:IQ_W];
  assign b = rx_word[IQ_W-1:0];
  assign c = h_word[2*IQ_W-1:IQ_W];
  assign d = h_word[IQ_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q <= 1'b0;
      p_ac   <= '0;
      p_bd   <= '0;
      p_bc   <= '0;
      p_ad   <= '0;
    end else begin
      vld1_q <= in_vld;
      p_ac   <= 32'(a) * 32'(c);
      p_bd   <= 32'(b) * 32'(d);
      p_bc   <= 32'(b) * 32'(c);
      p_ad   <= 32'(a) * 32'(d);
    end
  end

  // conj(h): re = ac + bd, im = bc - ad
  always_comb begin
    sum_re = 33'(p_ac) + 33'(p_bd);
    sum_im = 33'(p_bc) - 33'(p_ad);
    res_re = round_sat(sum_re, FRAC_BITS);
    res_im = round_sat(sum_im, FRAC_BITS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_word <= '0;
      out_sat  <= 1'b0;
    end else begin
      out_vld <= vld1_q;
      out_sat <= vld1_q & (res_re[IQ_W] | res_im[IQ_W]);
      if (vld1_q)
        out_word <= {res_re[IQ_W-1:0], res_im[IQ_W-1:0]};
    end
  end

endmodule

// File: rtl/pbch_equalizer.sv
// PBCH equalizer: reads one channel estimate per received RE and streams out
// rx * conj(h) with a sticky saturation flag and an end-of-run done pulse.
module pbch_equalizer #(
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = est_pkg::BASE_ADDR,
  parameter int NUM_RE     = est_pkg::NUM_RE,
  parameter int FRAC       = est_pkg::FRAC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_vld,
  input  logic [RAM_WIDTH-1:0]  rx_data,
  input  logic [RAM_WIDTH-1:0]  eq_ram_dout,
  output logic [ADDR_WIDTH-1:0] eq_read_addr,
  output logic                  eq_read_enable,
  output logic                  eq_vld,
  output logic [RAM_WIDTH-1:0]  eq_data,
  output logic                  sat_flag,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = $clog2(NUM_RE);

  // Handshake: an RE is accepted on any cycle with rx_vld=1 while in RUN;
  // there is no back-pressure, so the read strobe equals the acceptance.
  est_pkg::eq_state_t    state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_cur;
  logic                  accept, last_acc;
  logic                  vld0_q;
  logic [RAM_WIDTH-1:0]  rx_q;
  logic                  last0_q, last1_q, done_q;
  logic                  mult_sat;

  assign accept   = (state_q == est_pkg::ST_RUN) && rx_vld;
  assign last_acc = accept && (cnt_q == CNT_W'(NUM_RE - 1));
  assign addr_cur = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(cnt_q);

  assign eq_read_enable = accept;
  assign eq_read_addr   = accept ? addr_cur : addr_q;
  assign busy           = (state_q != est_pkg::ST_IDLE);
  assign done           = done_q;
  assign dbg_state      = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      est_pkg::ST_IDLE:  if (start)    state_d = est_pkg::ST_RUN;
      est_pkg::ST_RUN:   if (last_acc) state_d = est_pkg::ST_DRAIN;
      est_pkg::ST_DRAIN: if (done_q)   state_d = est_pkg::ST_IDLE;
      default:                         state_d = est_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= est_pkg::ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      vld0_q   <= 1'b0;
      rx_q     <= '0;
      last0_q  <= 1'b0;
      last1_q  <= 1'b0;
      done_q   <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      state_q <= state_d;
      vld0_q  <= accept;
      // The last-RE marker runs alongside the multiplier so done lines up
      // with the final eq_vld.
      last0_q <= last_acc;
      last1_q <= last0_q;
      done_q  <= last1_q;
      if (accept) begin
        rx_q   <= rx_data;
        addr_q <= addr_cur;
      end
      if (state_q == est_pkg::ST_IDLE && start)
        cnt_q <= '0;
      else if (accept)
        cnt_q <= cnt_q + 1'b1;
      if (state_q == est_pkg::ST_IDLE && start)
        sat_flag <= 1'b0;
      else if (eq_vld && mult_sat)
        sat_flag <= 1'b1;
    end
  end

  cmplx_conj_mult #(
    .FRAC_BITS (FRAC)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (vld0_q),
    .rx_word  (rx_q),
    .h_word   (eq_ram_dout),
    .out_vld  (eq_vld),
    .out_word (eq_data),
    .out_sat  (mult_sat)
  );

endmodule
